// File: rtl/morse_tx_scheduler.sv
// morse_tx_scheduler: queues letter codes and keys them out as Morse.
// clock/reset_n; letter/letter_valid/letter_ready push side;
// tick_in unit strobe; enable gates dequeue; flush aborts all;
// out key line; busy; fifo_count; err on invalid code.
// MORSE_INT_TICK_EN: use internal TICK_CYCLES divider, ignore tick_in.
module morse_tx_scheduler #(
  parameter int unsigned TICK_CYCLES = 25000000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [4:0] letter,
  input  logic       letter_valid,
  output logic       letter_ready,
  input  logic       tick_in,
  input  logic       enable,
  input  logic       flush,
  output logic       out,
  output logic       busy,
  output logic [3:0] fifo_count,
  output logic       err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [3:0] DEPTH = 4'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    GAP
  } state_t;

  state_t state_q, state_d;

  logic [4:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [3:0]    cnt_q;
  logic [4:0]    code_q, code_d;
  logic [13:0]   pat_q, pat_d;
  logic [3:0]    len_q, len_d;
  logic [3:0]    idx_q, idx_d;
  logic [2:0]    gap_q, gap_d;
  logic          out_q, out_d;
  logic          rdy_q;
  logic          err_c;
  logic          tick;
  logic          push, pop;

`ifdef MORSE_INT_TICK_EN
  logic [31:0] div_q;
  logic        unused_tick;

  assign unused_tick = tick_in;
  assign tick = (div_q == 32'd0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= TICK_CYCLES - 1;
    end else if (tick) begin
      div_q <= TICK_CYCLES - 1;
    end else begin
      div_q <= div_q - 32'd1;
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg = ^TICK_CYCLES;
  assign tick = tick_in;
`endif

  // 14-bit key pattern, MSB first: 1 = key down unit, 0 = key up unit
  function automatic logic [13:0] morse_pat(input logic [4:0] c);
    case (c)
      5'd0:    morse_pat = {5'b10111, 9'd0};
      5'd1:    morse_pat = {9'b111010101, 5'd0};
      5'd2:    morse_pat = {11'b11101011101, 3'd0};
      5'd3:    morse_pat = {7'b1110101, 7'd0};
      5'd4:    morse_pat = {1'b1, 13'd0};
      5'd5:    morse_pat = {9'b101011101, 5'd0};
      5'd6:    morse_pat = {9'b111011101, 5'd0};
      5'd7:    morse_pat = {7'b1010101, 7'd0};
      5'd8:    morse_pat = {3'b101, 11'd0};
      5'd9:    morse_pat = {13'b1011101110111, 1'b0};
      5'd10:   morse_pat = {9'b111010111, 5'd0};
      5'd11:   morse_pat = {9'b101110101, 5'd0};
      5'd12:   morse_pat = {7'b1110111, 7'd0};
      5'd13:   morse_pat = {5'b11101, 9'd0};
      5'd14:   morse_pat = {11'b11101110111, 3'd0};
      5'd15:   morse_pat = {11'b10111011101, 3'd0};
      5'd16:   morse_pat = {13'b1110111010111, 1'b0};
      5'd17:   morse_pat = {7'b1011101, 7'd0};
      5'd18:   morse_pat = {5'b10101, 9'd0};
      5'd19:   morse_pat = {3'b111, 11'd0};
      5'd20:   morse_pat = {7'b1010111, 7'd0};
      5'd21:   morse_pat = {9'b101010111, 5'd0};
      5'd22:   morse_pat = {9'b101110111, 5'd0};
      5'd23:   morse_pat = {11'b11101010111, 3'd0};
      5'd24:   morse_pat = {13'b1110101110111, 1'b0};
      5'd25:   morse_pat = {11'b11101110101, 3'd0};
      default: morse_pat = 14'd0;
    endcase
  endfunction

  // length up to and including the last key-down unit
  function automatic logic [3:0] len_of(input logic [13:0] p);
    len_of = 4'd0;
    for (int i = 13; i >= 0; i--) begin
      if (p[i]) len_of = 4'(14 - i);
    end
  endfunction

  assign letter_ready = rdy_q && (cnt_q < DEPTH) && !flush;
  assign push = letter_valid && letter_ready;
  assign pop  = (state_q == IDLE) && enable && (cnt_q != 4'd0) && !flush;

  always_ff @(posedge clock) begin
    if (push) mem[wr_q] <= letter;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= 4'd0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= 4'd0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      if (push && !pop) cnt_q <= cnt_q + 4'd1;
      if (pop && !push) cnt_q <= cnt_q - 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    code_d  = code_q;
    pat_d   = pat_q;
    len_d   = len_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    err_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        out_d = 1'b0;
        if (pop) begin
          code_d  = mem[rd_q];
          state_d = LOAD;
        end
      end
      LOAD: begin
        pat_d = morse_pat(code_q);
        len_d = len_of(pat_d);
        idx_d = 4'd0;
        unique case (1'b1)
          (code_q < 5'd26): state_d = SEND;
          (code_q == 5'd26): begin
            state_d = GAP;
            gap_d   = 3'd7;
          end
          default: begin
            state_d = IDLE;
            err_c   = 1'b1;
          end
        endcase
      end
      SEND: begin
        if (tick) begin
          if (idx_q < len_q) begin
            out_d = pat_q[13];
            pat_d = {pat_q[12:0], 1'b0};
            idx_d = idx_q + 4'd1;
          end else begin
            // this tick is already the first of the 3 gap units
            out_d   = 1'b0;
            state_d = GAP;
            gap_d   = 3'd2;
          end
        end
      end
      GAP: begin
        out_d = 1'b0;
        if (tick) begin
          gap_d = gap_q - 3'd1;
          if (gap_q == 3'd1) state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      out_q   <= 1'b0;
      code_q  <= 5'd0;
      pat_q   <= 14'd0;
      len_q   <= 4'd0;
      idx_q   <= 4'd0;
      gap_q   <= 3'd0;
      rdy_q   <= 1'b0;
    end else begin
      rdy_q  <= 1'b1;
      code_q <= code_d;
      pat_q  <= pat_d;
      len_q  <= len_d;
      idx_q  <= idx_d;
      gap_q  <= gap_d;
      if (flush) begin
        state_q <= IDLE;
        out_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        out_q   <= out_d;
      end
    end
  end

  assign out        = out_q;
  assign err        = err_c;
  assign busy       = (state_q != IDLE) || (cnt_q != 4'd0);
  assign fifo_count = cnt_q;

endmodule

// File: tb/tb_morse_tx_scheduler.sv
// tb_morse_tx_scheduler: directed vectors, per-tick out scoreboard.
// tick_in pulses every 4 cycles; letters pushed right after a tick.
module tb_morse_tx_scheduler;

  logic       clock;
  logic       reset_n;
  logic [4:0] letter;
  logic       letter_valid;
  logic       letter_ready;
  logic       tick_in;
  logic       enable;
  logic       flush;
  logic       out;
  logic       busy;
  logic [3:0] fifo_count;
  logic       err;

  int   vecs;
  int   miss;
  logic exp_q[$];
  logic exp_bit;
  logic armed;

  morse_tx_scheduler #(
    .TICK_CYCLES(4),
    .FIFO_DEPTH (4)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .letter      (letter),
    .letter_valid(letter_valid),
    .letter_ready(letter_ready),
    .tick_in     (tick_in),
    .enable      (enable),
    .flush       (flush),
    .out         (out),
    .busy        (busy),
    .fifo_count  (fifo_count),
    .err         (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    tick_in = 1'b0;
    forever begin
      repeat (3) @(posedge clock);
      #1 tick_in = 1'b1;
      @(posedge clock);
      #1 tick_in = 1'b0;
    end
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // one scoreboard entry per tick that the DUT spends keying
  initial begin
    armed = 1'b0;
    forever begin
      @(negedge clock);
      if (armed) begin
        exp_bit = exp_q.pop_front();
        check("out_bit", 32'(out), 32'(exp_bit));
      end
      armed = (tick_in === 1'b1) && (busy === 1'b1) &&
              (reset_n === 1'b1) && (exp_q.size() > 0);
    end
  end

  task automatic wait_tick_edge();
    int n;
    n = 0;
    do begin
      @(posedge clock);
      n++;
    end while (tick_in !== 1'b1 && n < 8);
    #1;
  endtask

  task automatic push_letter(input logic [4:0] c);
    letter       = c;
    letter_valid = 1'b1;
    @(posedge clock);
    #1;
    letter_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int exp_cyc);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 400) begin
      @(posedge clock);
      #1;
      n++;
    end
    check(name, 32'(n), 32'(exp_cyc));
  endtask

  task automatic expect_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(bits[i]);
  endtask

  task automatic send(input logic [4:0] c, input logic [31:0] bits,
                      input int n, input string name);
    wait_tick_edge();
    expect_bits(bits, n);
    push_letter(c);
    wait_idle({name, "_cycles"}, 4 * n - 1);
    @(negedge clock);
    #1;
    check({name, "_sb_left"}, 32'(exp_q.size()), 0);
  endtask

  task automatic watch_quiet(input string name, input int cyc);
    int hi;
    hi = 0;
    repeat (cyc) begin
      @(negedge clock);
      if (out !== 1'b0 || busy !== 1'b0) hi++;
    end
    check(name, 32'(hi), 0);
  endtask

  initial begin
    #100000;
    miss++;
    $display("FAIL watchdog: time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $fatal(1, "watchdog");
  end

  initial begin
    int e_cnt;
    int o_cnt;
    vecs         = 0;
    miss         = 0;
    reset_n      = 1'b0;
    letter       = 5'd0;
    letter_valid = 1'b0;
    enable       = 1'b0;
    flush        = 1'b0;

    repeat (3) @(posedge clock);
    #1;
    check("rst_out", 32'(out), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_count", 32'(fifo_count), 0);
    check("rst_ready", 32'(letter_ready), 0);
    check("rst_err", 32'(err), 0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("ready_pre_edge", 32'(letter_ready), 0);
    @(posedge clock);
    #1;
    check("ready_post_edge", 32'(letter_ready), 1);
    enable = 1'b1;

    send(5'd4, 32'b1000, 4, "E");
    send(5'd0, 32'b10111000, 8, "A");
    send(5'd19, 32'b111000, 6, "T");
    send(5'd10, 32'b111010111000, 12, "K");
    send(5'd26, 32'b0000000, 7, "space");

    // fill queue with dequeue blocked
    enable = 1'b0;
    wait_tick_edge();
    push_letter(5'd4);
    push_letter(5'd19);
    push_letter(5'd8);
    push_letter(5'd13);
    check("full_count", 32'(fifo_count), 4);
    check("full_ready", 32'(letter_ready), 0);
    check("full_busy", 32'(busy), 1);
    push_letter(5'd0);
    check("full_hold", 32'(fifo_count), 4);
    check("full_out", 32'(out), 0);
    wait_tick_edge();
    expect_bits(32'b1000, 4);
    expect_bits(32'b111000, 6);
    expect_bits(32'b101000, 6);
    expect_bits(32'b11101000, 8);
    enable = 1'b1;
    wait_idle("drain_cycles", 96);
    @(negedge clock);
    #1;
    check("drain_sb_left", 32'(exp_q.size()), 0);
    check("drain_count", 32'(fifo_count), 0);

    // invalid code
    wait_tick_edge();
    push_letter(5'd31);
    e_cnt = 0;
    o_cnt = 0;
    repeat (12) begin
      @(negedge clock);
      if (err === 1'b1) e_cnt++;
      if (out !== 1'b0) o_cnt++;
    end
    check("inv_err_pulses", 32'(e_cnt), 1);
    check("inv_out_high", 32'(o_cnt), 0);
    check("inv_busy", 32'(busy), 0);
    send(5'd4, 32'b1000, 4, "E_after_inv");

    // flush during the 2nd bit of J, E queued behind it
    wait_tick_edge();
    expect_bits(32'b10, 2);
    push_letter(5'd9);
    push_letter(5'd4);
    check("pushpop_count", 32'(fifo_count), 1);
    wait_tick_edge();
    wait_tick_edge();
    flush        = 1'b1;
    letter       = 5'd4;
    letter_valid = 1'b1;
    #1;
    check("flush_ready", 32'(letter_ready), 0);
    @(posedge clock);
    #1;
    flush        = 1'b0;
    letter_valid = 1'b0;
    check("flush_out", 32'(out), 0);
    check("flush_count", 32'(fifo_count), 0);
    check("flush_busy", 32'(busy), 0);
    watch_quiet("flush_quiet", 40);
    check("flush_sb_left", 32'(exp_q.size()), 0);

    // reset during the 2nd bit of J
    wait_tick_edge();
    expect_bits(32'b10, 2);
    push_letter(5'd9);
    push_letter(5'd4);
    wait_tick_edge();
    wait_tick_edge();
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_out", 32'(out), 0);
    check("mid_rst_count", 32'(fifo_count), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_ready", 32'(letter_ready), 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check("mid_rst_ready_up", 32'(letter_ready), 1);
    watch_quiet("rst_quiet", 40);
    check("rst_sb_left", 32'(exp_q.size()), 0);

    send(5'd19, 32'b111000, 6, "T_after_rst");

    repeat (4) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/morse_tx_scheduler.md
MORSE_TX_SCHEDULER -- requirements
Module: morse_tx_scheduler

Interface
REQ-001 Parameter TICK_CYCLES, default 25000000, clock cycles per Morse time unit (internal divider only).
REQ-002 Parameter FIFO_DEPTH, default 4, letter queue entries (power of 2, 2..8).
REQ-003 The block SHALL provide these ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- letter  in  5  letter code: 0..25 = A..Z; 26 = word space; 27..31 invalid.
- letter_valid  in  1  letter offered.
- letter_ready  out  1  queue can accept.
- tick_in  in  1  external unit-time strobe, one cycle wide.
- enable  in  1  permits dequeuing new letters.
- flush  in  1  synchronous abort: clears queue and transmission.
- out  out  1  serial Morse output, high = key down.
- busy  out  1  not in IDLE, or queue non-empty.
- fifo_count  out  4  queued entries.
- err  out  1  one-cycle pulse when an invalid code is dequeued.

Function
REQ-004 A push SHALL occur on a cycle with letter_valid=1 and letter_ready=1; letter_ready = (fifo_count < FIFO_DEPTH) and flush=0.
REQ-005 A push and a pop in the same cycle SHALL leave fifo_count unchanged; a push while full SHALL be impossible, since letter_ready=0.
REQ-006 Internal table, 14-bit patterns sent MSB first: 1 = key down for one unit, 0 = key up for one unit. Dot = 1; dash = 111; intra-letter gap = 0. Examples: A=10111000000000, E=10000000000000, T=11100000000000, J=10111011101110; the remaining letters use standard Morse under the same encoding.
REQ-007 Transmitted length SHALL be L = 14 - (number of trailing zeros), i.e. up to and including the last 1; trailing zeros SHALL NOT be sent.
REQ-008 States: IDLE, LOAD, SEND, GAP.
REQ-009 IDLE: if enable=1 and fifo_count>0, pop and go to LOAD next cycle; otherwise stay. out=0.
REQ-010 LOAD (one cycle): latch pattern, L, bit index 0.
- Valid letter: go to SEND.
- Space: go to GAP with gap count 7.
- Invalid: pulse err and go to IDLE.
REQ-011 SEND: on each tick, out <= pattern[13-idx] and idx increments; after L bits, the next tick SHALL drive out=0 and enter GAP with gap count 3. That tick counts as gap unit 1.
REQ-012 GAP: out=0; each tick decrements the count; at count 0 go to IDLE. Result: exactly 3 low units after a letter and 7 after a space.
REQ-013 out SHALL change only on tick cycles, except on flush or reset.
REQ-014 Deasserting enable SHALL only block new pops; a letter in SEND or GAP SHALL complete.
REQ-015 flush=1 SHALL force out=0, fifo_count=0 and state IDLE on the next edge. flush SHALL win over a simultaneous push or pop.
REQ-016 A tick arriving in IDLE or LOAD SHALL be ignored.

Reset
REQ-017 reset_n=0 SHALL asynchronously force:
- state IDLE, out=0, err=0, busy=0, fifo_count=0, letter_ready=0.
- divider reloaded to TICK_CYCLES-1.
REQ-018 letter_ready SHALL rise on the first clock edge after reset_n deasserts.
REQ-019 Reset in mid-letter SHALL discard the letter and the queue with no further output.

Configuration
REQ-020 Macro MORSE_INT_TICK_EN:
- Defined: tick comes from an internal down-counter loaded with TICK_CYCLES-1, pulsing when it reaches 0 and reloading; tick_in is ignored.
- Undefined: tick = tick_in, and no divider logic exists.

Verification
REQ-021 The bench SHALL cover these scenarios (macro undefined, tick every 4 cycles):
- Push E (4) with enable=1 -> out pattern 1,0,0,0 over 4 ticks; then IDLE, busy=0.
- Push A (0) -> out 1,0,1,1,1 then 0,0,0 over 8 ticks.
- Push 26 -> out=0 for 7 ticks with busy=1; then IDLE.
- Push 5 letters with enable=0 -> first 4 accepted, fifo_count=4, letter_ready=0 on the 5th; enabling then drains in order.
- Push 31 -> err high for exactly one cycle, out stays 0, next letter proceeds.
- Assert flush, then separately reset_n=0, each during the 2nd bit of J (9) -> out=0, fifo_count=0, IDLE; no further output until a new push.
